// File: rtl/ntt_pkg.sv
// Shared NTT defaults, coefficient type and a width-parameterised bit reversal.
`default_nettype none

package ntt_pkg;
  localparam int COEF_W      = 32;
  localparam int DEF_MODULUS = 7681;
  localparam int DEF_RADIX   = 16;
  localparam int DEF_N_INV   = 7201;

  typedef logic [COEF_W-1:0] coef_t;

  // Reverses the low 'width' bits of v; bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[i] = v[width-1-i];
    return r;
  endfunction
endpackage

`default_nettype wire

// File: rtl/mod_const_mult.sv
// Combinational multiply by a constant followed by reduction mod MODULUS.
`default_nettype none

module mod_const_mult #(
  parameter int W         = 32,
  parameter int MODULUS   = 7681,
  parameter int CONST_VAL = 7201
) (
  input  logic [W-1:0] data,
  output logic [W-1:0] result
);
  localparam int PW = W + $clog2(CONST_VAL + 1);

  logic [PW-1:0] product;

  assign product = PW'(data) * PW'(CONST_VAL);
  assign result  = W'(product % PW'(MODULUS));
endmodule

`default_nettype wire

// File: rtl/intt_reorder_scale.sv
// Bit-reversed to natural-order ping-pong reorder with optional RADIX^-1 scaling.
// Define INTT_SCALE_EN to build the scaling multiplier; otherwise data passes unchanged.
`default_nettype none

module intt_reorder_scale
  import ntt_pkg::*;
#(
  parameter int W       = COEF_W,
  parameter int MODULUS = DEF_MODULUS,
  parameter int RADIX   = DEF_RADIX,
  parameter int N_INV   = DEF_N_INV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);
  localparam int            AW       = $clog2(RADIX);
  localparam logic [AW-1:0] LAST_IDX = AW'(RADIX - 1);

  if (((RADIX * N_INV) % MODULUS) != 1) begin : g_bad_n_inv
    $error("N_INV is not the inverse of RADIX modulo MODULUS");
  end

  logic [W-1:0]  bank [2][RADIX];
  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank;
  logic [AW-1:0] wr_cnt, rd_cnt, wr_addr;
  logic          wr_fire, rd_load;
  logic [W-1:0]  rd_word, scaled;

  assign in_ready = ~full[wr_bank];
  assign wr_fire  = in_valid & in_ready;
  assign rd_load  = full[rd_bank] & (~out_valid | out_ready);
  assign wr_addr  = AW'(bitrev(32'(wr_cnt), AW));
  assign rd_word  = bank[rd_bank][rd_cnt];

`ifdef INTT_SCALE_EN
  mod_const_mult #(
    .W         (W),
    .MODULUS   (MODULUS),
    .CONST_VAL (N_INV)
  ) u_scale (
    .data   (rd_word),
    .result (scaled)
  );
`else
  assign scaled = rd_word;
`endif

  // Write side only sets the bank it fills, read side only clears the bank it drains.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_cnt == LAST_IDX) full_nxt[wr_bank] = 1'b1;
    if (rd_load && rd_cnt == LAST_IDX) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) bank[wr_bank][wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST_IDX) wr_bank <= ~wr_bank;
      end
      if (rd_load) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == LAST_IDX) rd_bank <= ~rd_bank;
      end
    end
  end

  // Data and last hold their values while a beat is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (rd_load) begin
      out_data  <= scaled;
      out_valid <= 1'b1;
      out_last  <= (rd_cnt == LAST_IDX);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_intt_reorder_scale.sv
// Randomised scoreboard bench for intt_reorder_scale with literal pins on key frames.
`default_nettype none

module tb_intt_reorder_scale;
  import ntt_pkg::*;

  localparam int RADIX = 16;
  localparam int AW    = 4;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  coef_t in_data = '0;
  logic  in_valid = 1'b0;
  logic  in_ready;
  coef_t out_data;
  logic  out_valid;
  logic  out_ready = 1'b0;
  logic  out_last;

  always #5 clk = ~clk;

  intt_reorder_scale dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  int    total = 0;
  int    bad = 0;
  coef_t exp_q[$];
  logic  exp_l[$];
  coef_t log_q[$];
  coef_t frame[RADIX];
  int    wr_k = 0;
  logic  stall_prev = 1'b0;
  coef_t held_data;
  logic  held_last;
  logic  chk_stream = 1'b0;
  logic  rnd_done;

  function automatic coef_t model_scale(input coef_t v);
`ifdef INTT_SCALE_EN
    longint unsigned p;
    p = longint'(v) * 64'd7201;
    return coef_t'(p % 64'd7681);
`else
    return v;
`endif
  endfunction

  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) if (k[i]) r |= 1 << (AW - 1 - i);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: a frame of beats k lands at natural position rev4(k) and is queued scaled.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_l.delete();
      wr_k = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(held_data));
        check("hold_last", 64'(out_last), 64'(held_last));
      end
      if (chk_stream && in_valid) check("stream_in_ready", 64'(in_ready), 64'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_beat", 64'(out_valid), 64'd0);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
          check("out_last", 64'(out_last), 64'(exp_l.pop_front()));
        end
        log_q.push_back(out_data);
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      if (in_valid && in_ready) begin
        frame[rev4(wr_k)] = in_data;
        wr_k++;
        if (wr_k == RADIX) begin
          for (int i = 0; i < RADIX; i++) begin
            exp_q.push_back(model_scale(frame[i]));
            exp_l.push_back(i == RADIX - 1);
          end
          wr_k = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
  task automatic send(input coef_t v);
    int n;
    n = 0;
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_const_frame(input coef_t v);
    for (int k = 0; k < RADIX; k++) send(v);
  endtask

  task automatic send_rand_frame();
    for (int k = 0; k < RADIX; k++) send(coef_t'($urandom_range(7680, 0)));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reorder frame: beat k carries rev4(k), so natural order is 0..15 before scaling.
    out_ready = 1'b1;
    log_q.delete();
    for (int k = 0; k < RADIX; k++) send(coef_t'(rev4(k)));
    check("latency_before", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("latency_after", 64'(out_valid), 64'd1);
    check("latency_first_data", 64'(out_data), 64'd0);
    drain();
    check("reorder_count", 64'(log_q.size()), 64'd16);
`ifdef INTT_SCALE_EN
    check("reorder_idx1", 64'(log_q[1]), 64'd7201);
    check("reorder_idx15", 64'(log_q[15]), 64'd481);
`else
    check("reorder_idx1", 64'(log_q[1]), 64'd1);
    check("reorder_idx15", 64'(log_q[15]), 64'd15);
`endif

    // Constant frames pin the scaling arithmetic.
    log_q.delete();
    send_const_frame(coef_t'(16));
    drain();
    log_q.delete();
    send_const_frame(coef_t'(7680));
    drain();
`ifdef INTT_SCALE_EN
    check("scale_7680_first", 64'(log_q[0]), 64'd480);
    check("scale_7680_last", 64'(log_q[15]), 64'd480);
`else
    check("scale_7680_first", 64'(log_q[0]), 64'd7680);
    check("scale_7680_last", 64'(log_q[15]), 64'd7680);
`endif
    log_q.delete();
    send_const_frame(coef_t'(0));
    drain();
    check("scale_zero", 64'(log_q[7]), 64'd0);

    // Backpressure: two frames fill both banks, then the consumer wakes up.
    out_ready = 1'b0;
    send_rand_frame();
    send_rand_frame();
    repeat (3) @(posedge clk);
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send_rand_frame();
    drain();

    // Random consumer stalls with random source gaps.
    rnd_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 5; f++) begin
          for (int k = 0; k < RADIX; k++) begin
            if ($urandom_range(3, 0) == 0) begin
              @(posedge clk);
              #1;
            end
            send(coef_t'($urandom_range(7680, 0)));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(1, 0) == 1);
        end
      end
    join
    drain();

    // Back-to-back frames: a fill wrap coincides with a drain wrap, input never stalls.
    out_ready  = 1'b1;
    chk_stream = 1'b1;
    for (int f = 0; f < 4; f++) send_rand_frame();
    chk_stream = 1'b0;
    drain();

    // Reset after seven beats of a partial frame.
    for (int k = 0; k < 7; k++) send(coef_t'($urandom_range(7680, 1)));
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_midframe");
    @(posedge clk);
    #1;
    rst = 1'b1;
    log_q.delete();
    send_rand_frame();
    drain();
    check("after_rst1_count", 64'(log_q.size()), 64'd16);

    // Reset in the middle of draining a frame.
    out_ready = 1'b0;
    for (int k = 0; k < RADIX; k++) send(coef_t'($urandom_range(7680, 1)));
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_middrain");
    @(posedge clk);
    #1;
    rst = 1'b1;
    log_q.delete();
    send_rand_frame();
    drain();
    check("after_rst2_count", 64'(log_q.size()), 64'd16);

    repeat (3) @(posedge clk);
    #1;
    check("final_out_valid", 64'(out_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
